// File: rtl/dsp_sequencer.sv
// rtl/dsp_sequencer.sv - per-sample instruction sequencer feeding the DSP core
// Streams L words from a registered instruction memory per sample tick, drains with NOPs, then pulses done.
module dsp_sequencer #(
    parameter int OPCODE_WIDTH      = 6,
    parameter int SAMPLE_ADDR_WIDTH = 10,
    parameter int PARAM_ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH       = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH,
    parameter int PC_WIDTH          = 10,
    parameter int DRAIN_CYCLES      = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic [PC_WIDTH-1:0]    program_length,
    output logic [PC_WIDTH-1:0]    instr_rd_addr,
    input  logic [INSTR_WIDTH-1:0] instr_rd_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    input  logic                   overrun_clear
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  r_len;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_overrun;
    logic                 w_run_last;
    logic                 w_drain_last;

    // pc runs one ahead of the emitted word, so pc==L marks the cycle emitting word L-1
    assign w_run_last   = (r_pc == r_len);
    assign w_drain_last = (r_drain_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (sample_tick) w_next_state = S_PRIME;
            S_PRIME: w_next_state = (r_len != '0) ? S_RUN : S_DRAIN;
            S_RUN:   if (w_run_last) w_next_state = S_DRAIN;
            S_DRAIN: if (w_drain_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_len       <= '0;
            r_drain_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_pc <= '0;
                    if (sample_tick) begin
                        r_len <= program_length;
                    end
                end
                S_PRIME: begin
                    r_pc        <= r_pc + 1'b1;
                    r_drain_cnt <= DRAIN_INIT;
                end
                S_RUN: begin
                    // hold on the last word so a full-length program never wraps the address
                    if (!w_run_last) begin
                        r_pc <= r_pc + 1'b1;
                    end
                    r_drain_cnt <= DRAIN_INIT;
                end
                S_DRAIN: begin
                    if (w_drain_last) begin
                        r_pc <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: begin
                    r_pc <= '0;
                end
            endcase
        end
    end

    // a new set beats a simultaneous clear so no overrun is ever lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (sample_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (overrun_clear) begin
            r_overrun <= 1'b0;
        end
    end

    always_comb begin
        instruction = '0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_PRIME: begin
                busy = 1'b1;
            end
            S_RUN: begin
                busy        = 1'b1;
                instruction = instr_rd_data;
            end
            S_DRAIN: begin
                busy = 1'b1;
                done = w_drain_last;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign instr_rd_addr = r_pc;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_dsp_sequencer.sv
// tb/tb_dsp_sequencer.sv - scoreboard bench for dsp_sequencer
// Expected words are queued with their due cycle when a tick is driven and popped as the core sees them.
module tb_dsp_sequencer;

    localparam int PC_W  = 10;
    localparam int IW    = 26;
    localparam int DRAIN = 5;

    typedef struct {
        int            cyc;
        logic [IW-1:0] word;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            sample_tick;
    logic [PC_W-1:0] program_length;
    logic [PC_W-1:0] instr_rd_addr;
    logic [IW-1:0]   instr_rd_data;
    logic [IW-1:0]   instruction;
    logic            busy;
    logic            done;
    logic            overrun;
    logic            overrun_clear;

    logic [IW-1:0]   mem [1024];
    exp_t            sb_q[$];
    int              cyc;
    int              run_start;
    int              n_tests;
    int              n_fail;

    dsp_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .program_length (program_length),
        .instr_rd_addr  (instr_rd_addr),
        .instr_rd_data  (instr_rd_data),
        .instruction    (instruction),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun),
        .overrun_clear  (overrun_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) instr_rd_data <= mem[instr_rd_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (instruction != '0) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_instr", 32'(instruction), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("instr_word", 32'(instruction), 32'(e.word));
                check_eq("instr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check_eq("missing_instr", 32'd0, 32'(e.word));
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        sb_check();
    endtask

    // Drives an accepted tick on the current cycle (cycle 0) and follows the run to its first IDLE cycle.
    task automatic run_program(input int len, input int extra_at, input int clear_at);
        int t_end;
        exp_t e;
        t_end          = len + 2 + DRAIN;
        run_start      = cyc;
        sample_tick    = 1'b1;
        program_length = PC_W'(len);
        for (int k = 0; k < len; k++) begin
            e.cyc  = cyc + 2 + k;
            e.word = mem[k];
            sb_q.push_back(e);
        end
        for (int t = 1; t <= t_end; t++) begin
            step();
            sample_tick    = 1'b0;
            overrun_clear  = 1'b0;
            program_length = PC_W'($urandom);
            check_eq("busy", 32'(busy), 32'(t <= len + 1 + DRAIN));
            check_eq("done", 32'(done), 32'(t == len + 1 + DRAIN));
            if (t <= len + 1) check_eq("rd_addr", 32'(instr_rd_addr), 32'(t - 1));
            if (extra_at >= 0 && t > extra_at) check_eq("overrun_set", 32'(overrun), 32'd1);
            if (t == extra_at) sample_tick = 1'b1;
            if (t == clear_at) overrun_clear = 1'b1;
        end
    endtask

    task automatic clear_overrun();
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        step();
        check_eq("overrun_cleared", 32'(overrun), 32'd0);
    endtask

    initial begin
        exp_t e;
        n_tests        = 0;
        n_fail         = 0;
        cyc            = 0;
        reset          = 1'b1;
        sample_tick    = 1'b0;
        program_length = '0;
        overrun_clear  = 1'b0;
        for (int k = 0; k < 1024; k++) mem[k] = IW'(((k + 1) << 22) | (k + 1));

        step();
        step();
        check_eq("rst_instr", 32'(instruction), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_addr", 32'(instr_rd_addr), 32'd0);
        reset = 1'b0;
        step();

        run_program(4, -1, -1);
        run_program(0, -1, -1);

        run_program(4, 3, -1);
        while (cyc < run_start + 20) step();
        check_eq("overrun_hold", 32'(overrun), 32'd1);
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        check_eq("overrun_clear", 32'(overrun), 32'd0);
        run_program(4, 2, 2);
        clear_overrun();

        // reset at cycle 5 of an L=8 run, with a coincident tick that must be dropped
        run_start      = cyc;
        sample_tick    = 1'b1;
        program_length = PC_W'(8);
        for (int k = 0; k < 4; k++) begin
            e.cyc  = cyc + 2 + k;
            e.word = mem[k];
            sb_q.push_back(e);
        end
        for (int t = 1; t <= 5; t++) begin
            step();
            sample_tick = 1'b0;
            check_eq("rr_busy", 32'(busy), 32'd1);
            check_eq("rr_done", 32'(done), 32'd0);
        end
        reset       = 1'b1;
        sample_tick = 1'b1;
        step();
        reset       = 1'b0;
        sample_tick = 1'b0;
        check_eq("rr_instr", 32'(instruction), 32'd0);
        check_eq("rr_busy_off", 32'(busy), 32'd0);
        check_eq("rr_addr", 32'(instr_rd_addr), 32'd0);
        check_eq("rr_done_off", 32'(done), 32'd0);
        check_eq("rr_overrun", 32'(overrun), 32'd0);
        step();
        check_eq("rr_idle_busy", 32'(busy), 32'd0);
        check_eq("rr_idle_done", 32'(done), 32'd0);
        run_program(8, -1, -1);

        run_program(2, -1, -1);
        run_program(2, -1, -1);
        run_program(2, 8, -1);
        for (int t = 0; t < 4; t++) begin
            step();
            check_eq("ignored_tick_idle", 32'(busy), 32'd0);
        end
        clear_overrun();

        run_program(1023, -1, -1);
        step();
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
